// File: rtl/mac_scheduler_pkg.sv
// mac_scheduler_pkg
//   Shared definitions for the MAC scheduler slice: default sizes, the
//   scheduler state encoding and a width helper used for counter/id widths.
//   No ports (package).
package mac_scheduler_pkg;

  localparam int BITSIZE_DEFAULT = 16;
  localparam int N_DEFAULT       = 6;
  localparam int NREQ_DEFAULT    = 4;

  // One-bit state: either waiting for a request or stepping through a job.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Number of bits needed to index 'value' items, never less than one so a
  // single-entry counter or id still has a real signal behind it.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/mac_scheduler_if.sv
// mac_scheduler_if
//   Bundles the requester-side and datapath-side signals of the MAC scheduler.
//   Ports (signals):
//     req      requester request levels          (requesters -> scheduler)
//     x_flat   packed x vectors, [(r*N+j)*BITSIZE +: BITSIZE]
//     w_flat   packed w vectors, same packing
//     b_flat   packed biases, [r*BITSIZE +: BITSIZE]
//     mac_a    multiplier operand A              (scheduler -> datapath)
//     mac_b    multiplier operand B
//     mac_acc  adder operand B (running accumulator)
//     mac_sum  adder result                      (datapath -> scheduler)
//     grant    one-hot requester being served
//     busy     job in progress
//     y        result of last completed job
//     y_valid  one-cycle pulse, y/y_id valid
//     y_id     requester index of y
//   Modports: slave = scheduler view, master = requesters + datapath view.
interface mac_scheduler_if
  import mac_scheduler_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEFAULT,
  parameter int N       = N_DEFAULT,
  parameter int NREQ    = NREQ_DEFAULT
);

  localparam int ID_W = clog2_min1(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ*N*BITSIZE-1:0] x_flat;
  logic [NREQ*N*BITSIZE-1:0] w_flat;
  logic [NREQ*BITSIZE-1:0]   b_flat;
  logic [BITSIZE-1:0]        mac_a;
  logic [BITSIZE-1:0]        mac_b;
  logic [BITSIZE-1:0]        mac_acc;
  logic [BITSIZE-1:0]        mac_sum;
  logic [NREQ-1:0]           grant;
  logic                      busy;
  logic [BITSIZE-1:0]        y;
  logic                      y_valid;
  logic [ID_W-1:0]           y_id;

  modport slave (
    input  req, x_flat, w_flat, b_flat, mac_sum,
    output mac_a, mac_b, mac_acc, grant, busy, y, y_valid, y_id
  );

  modport master (
    output req, x_flat, w_flat, b_flat, mac_sum,
    input  mac_a, mac_b, mac_acc, grant, busy, y, y_valid, y_id
  );

endinterface

// File: rtl/mac_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first set request bit at or
//   above 'pointer', wrapping around past NREQ-1 back to 0.
//   Ports:
//     req          in   NREQ  request levels
//     pointer      in   ID_W  highest-priority index this round
//     grant_onehot out  NREQ  one-hot winner (all zero when no request)
//     index        out  ID_W  binary winner index (0 when no request)
//     any_req      out  1     at least one request present
module rr_arbiter
  import mac_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int ID_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] pointer,
  output logic [NREQ-1:0] grant_onehot,
  output logic [ID_W-1:0] index,
  output logic            any_req
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Walk the requesters starting at the pointer; the modulo keeps the scan
  // inside 0..NREQ-1 even when NREQ is not a power of two. The first hit wins
  // and later hits are ignored via 'found'.
  always_comb begin
    grant_onehot = '0;
    index        = '0;
    found        = 1'b0;
    cand         = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(pointer) + k) % NREQ);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        index              = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler
//   Time-shares one multiply/add datapath between NREQ requesters. A granted
//   job loads its bias into the accumulator, then walks N elements feeding
//   x[j], w[j] and the accumulator to the datapath and capturing its sum.
//   The final sum is presented on y with the requester id for one cycle.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-low reset
//     bus    mac_scheduler_if.slave (requests, operands, datapath, results)
module mac_scheduler
  import mac_scheduler_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEFAULT,
  parameter int N       = N_DEFAULT,
  parameter int NREQ    = NREQ_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  mac_scheduler_if.slave bus
);

  localparam int ID_W  = clog2_min1(NREQ);
  localparam int CNT_W = clog2_min1(N);
  localparam int EL_W  = clog2_min1(NREQ * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);

  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      g_q, g_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      y_id_q, y_id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITSIZE-1:0]   acc_q, acc_d;
  logic [BITSIZE-1:0]   y_q, y_d;
  logic                 busy_q, busy_d;
  logic                 y_valid_q, y_valid_d;

  logic [NREQ-1:0]      arb_grant;
  logic [ID_W-1:0]      arb_index;
  logic                 arb_any;

  logic [NREQ*N-1:0][BITSIZE-1:0] x_arr;
  logic [NREQ*N-1:0][BITSIZE-1:0] w_arr;
  logic [NREQ-1:0][BITSIZE-1:0]   b_arr;
  logic [EL_W-1:0]                elem_idx;
  logic [BITSIZE-1:0]             bias_sel;
  logic [BITSIZE-1:0]             mac_a_c, mac_b_c, mac_acc_c;

  // Flat buses viewed as element arrays so selection uses exact-width indices.
  assign x_arr = bus.x_flat;
  assign w_arr = bus.w_flat;
  assign b_arr = bus.b_flat;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req          (bus.req),
    .pointer      (ptr_q),
    .grant_onehot (arb_grant),
    .index        (arb_index),
    .any_req      (arb_any)
  );

  // Operand selection. Everything comes from registered g/cnt/acc so the
  // datapath sees stable operands for the whole cycle; outside a job the
  // operands are forced to zero so the shared datapath stays quiet.
  always_comb begin
    elem_idx  = EL_W'(int'(g_q) * N + int'(cnt_q));
    bias_sel  = b_arr[arb_index];
    mac_a_c   = '0;
    mac_b_c   = '0;
    mac_acc_c = '0;
    if (state_q == ACC) begin
      mac_a_c   = x_arr[elem_idx];
      mac_b_c   = w_arr[elem_idx];
      mac_acc_c = acc_q;
    end
  end

  // Next-state logic. IDLE waits for any request and loads the winner's bias
  // so the first ACC cycle already adds x0*w0 to it. ACC captures the datapath
  // sum every edge; on the last element the sum also becomes y and the
  // pointer moves past the served requester so a still-high req waits its turn.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    y_id_d    = y_id_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    busy_d    = busy_q;
    y_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          g_d     = arb_index;
          acc_d   = bias_sel;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = bus.mac_sum;
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          y_d       = bus.mac_sum;
          y_id_d    = g_q;
          y_valid_d = 1'b1;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = (g_q == ID_LAST) ? '0 : g_q + ID_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset drops any job in flight without a y_valid and
  // returns the round-robin pointer to requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      y_id_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      y_id_q    <= y_id_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.mac_a   = mac_a_c;
  assign bus.mac_b   = mac_b_c;
  assign bus.mac_acc = mac_acc_c;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_id    = y_id_q;

endmodule
